apb_master_arb: RTL

//  Round-robin arbiter and APB phase sequencer that shares one APB master port among MASTER_PORTS cores.

---
 rtl/apb_master_arb.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/apb_master_arb.sv
// Round-robin APB arbiter: shares one downstream APB master port among
// MASTER_PORTS cores, regenerates SETUP/ACCESS phases from latched requests
// and bounds slave wait states with a timeout.
module apb_master_arb #(
  parameter int                    MASTER_PORTS = 4,
  parameter int                    BUS_WIDTH    = 16,
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    TIMEOUT      = 255,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
  input  logic [MASTER_PORTS-1:0]            S_PWRITE,
  input  logic [MASTER_PORTS-1:0]            S_PSELx,
  input  logic [MASTER_PORTS-1:0]            S_PENABLE,
  input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]            S_PREADY,
  output logic [BUS_WIDTH-1:0]               M_PADDR,
  output logic                               M_PWRITE,
  output logic                               M_PSELx,
  output logic                               M_PENABLE,
  output logic [DATA_WIDTH-1:0]              M_PWDATA,
  input  logic [DATA_WIDTH-1:0]              M_PRDATA,
  input  logic                               M_PREADY,
  output logic [MASTER_PORTS-1:0]            grant,
  output logic                               timeout_err,
  input  logic                               timeout_clr
);

  localparam int IW = $clog2(MASTER_PORTS);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT < 1) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [BUS_WIDTH-1:0]     paddr_q, paddr_d;
  logic                     pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]    pwdata_q, pwdata_d;
  logic                     psel_q, psel_d;
  logic                     penable_q, penable_d;
  logic [MASTER_PORTS-1:0]  grant_q, grant_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     tout_err_q, tout_err_d;

  logic                     found;
  logic [IW-1:0]            win;
  logic [IW-1:0]            cand;
  logic                     in_access;
  logic                     tout_fire;
  logic                     xfer_done;

  // Phases are regenerated locally, so the cores' PENABLE carries no information.
  logic unused_penable;
  assign unused_penable = ^S_PENABLE;

  // Round-robin pick: first requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned off = 0; off < MASTER_PORTS; off++) begin
      cand = IW'((32'(rr_ptr_q) + off) % MASTER_PORTS);
      if (!found && S_PSELx[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Completion detect; S_PREADY/S_PRDATA are combinational so the core sees the slave's cycle.
  always_comb begin
    in_access = (state_q == ACCESS);
    tout_fire = in_access && !M_PREADY && (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    xfer_done = in_access && (M_PREADY || tout_fire);
    S_PREADY  = '0;
    S_PRDATA  = '0;
    for (int unsigned i = 0; i < MASTER_PORTS; i++) begin
      if (xfer_done && (idx_q == IW'(i))) begin
        S_PREADY[i] = 1'b1;
        S_PRDATA[i*DATA_WIDTH +: DATA_WIDTH] = M_PREADY ? M_PRDATA : TIMEOUT_DATA;
      end
    end
  end

  // Next-state and registered-output computation for the phase sequencer.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    tout_err_d = tout_fire ? 1'b1 : (timeout_clr ? 1'b0 : tout_err_q);
    unique case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        grant_d   = '0;
        if (found) begin
          state_d  = SETUP;
          idx_d    = win;
          paddr_d  = S_PADDR[win*BUS_WIDTH +: BUS_WIDTH];
          pwrite_d = S_PWRITE[win];
          pwdata_d = S_PWDATA[win*DATA_WIDTH +: DATA_WIDTH];
          psel_d   = 1'b1;
          for (int unsigned i = 0; i < MASTER_PORTS; i++) begin
            grant_d[i] = (win == IW'(i));
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (xfer_done) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          grant_d   = '0;
          rr_ptr_d  = (idx_q == IW'(MASTER_PORTS - 1)) ? '0 : idx_q + 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      grant_q    <= '0;
      cnt_q      <= '0;
      tout_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      tout_err_q <= tout_err_d;
    end
  end

  assign M_PADDR     = paddr_q;
  assign M_PWRITE    = pwrite_q;
  assign M_PWDATA    = pwdata_q;
  assign M_PSELx     = psel_q;
  assign M_PENABLE   = penable_q;
  assign grant       = grant_q;
  assign timeout_err = tout_err_q;

endmodule
